// File: rtl/p14_score_bcd_if.sv
// Score/BCD display bus: frame sync and binary score in, BCD digits and status out.
interface p14_score_bcd_if;
    logic       v_sync;
    logic [7:0] score;
    logic [3:0] bcd_hundreds;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [7:0] best_score;
    logic       bcd_valid;
    logic       bcd_ready;
    logic       busy;

    modport master (
        output v_sync, score,
        input  bcd_hundreds, bcd_tens, bcd_ones, best_score, bcd_valid, bcd_ready, busy
    );

    modport slave (
        input  v_sync, score,
        output bcd_hundreds, bcd_tens, bcd_ones, best_score, bcd_valid, bcd_ready, busy
    );
endinterface

// File: rtl/p14_score_bcd.sv
// Once-per-frame binary-to-BCD converter (double dabble, one shift per clock) with best-score tracking.
// state | meaning
// IDLE  | waiting for a v_sync leading edge
// SHIFT | eight add-3/shift steps on the 20-bit register
// DONE  | publish digits, pulse bcd_valid, return to IDLE
module p14_score_bcd #(
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter bit SKIP_UNCHANGED  = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    p14_score_bcd_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Inactive level of v_sync; also the reset value of the delayed copy.
    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

    state_t      state_q, state_d;
    logic        v_sync_d;
    logic [19:0] shreg;
    logic [2:0]  cnt;
    logic [7:0]  last_score;
    logic [7:0]  best_q;
    logic [3:0]  hund_q, tens_q, ones_q;
    logic        valid_q, ready_q, busy_q;

    logic        sync_act, sync_d_act, trigger, skip, start;

    function automatic logic [19:0] dabble(input logic [19:0] r);
        logic [19:0] a;
        a = r;
        if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
        if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
        if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
        return {a[18:0], 1'b0};
    endfunction

    always_comb begin
        sync_act   = (bus.v_sync != SYNC_IDLE);
        sync_d_act = (v_sync_d != SYNC_IDLE);
        trigger    = sync_act && !sync_d_act;
        skip       = SKIP_UNCHANGED && ready_q && (bus.score == last_score);
        start      = 1'b0;
        state_d    = state_q;
        case (state_q)
            IDLE: begin
                if (trigger && !skip) begin
                    start   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 3'd7) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sync_d   <= SYNC_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            last_score <= '0;
            best_q     <= '0;
            hund_q     <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            v_sync_d <= bus.v_sync;
            valid_q  <= 1'b0;
            if (start) begin
                shreg      <= {12'b0, bus.score};
                last_score <= bus.score;
                cnt        <= '0;
                busy_q     <= 1'b1;
                if (bus.score > best_q) best_q <= bus.score;
            end
            if (state_q == SHIFT) begin
                shreg <= dabble(shreg);
                cnt   <= cnt + 3'd1;
            end
            if (state_q == DONE) begin
                hund_q  <= shreg[19:16];
                tens_q  <= shreg[15:12];
                ones_q  <= shreg[11:8];
                valid_q <= 1'b1;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
            end
        end
    end

    assign bus.bcd_hundreds = hund_q;
    assign bus.bcd_tens     = tens_q;
    assign bus.bcd_ones     = ones_q;
    assign bus.best_score   = best_q;
    assign bus.bcd_valid    = valid_q;
    assign bus.bcd_ready    = ready_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_p14_score_bcd.sv
// Bench for p14_score_bcd: two instances (SKIP_UNCHANGED 0 and 1) driven together and checked against a timeline model.
module tb_p14_score_bcd;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v_sync;
    logic [7:0] score;

    always #20 clk = ~clk;

    p14_score_bcd_if bus0();
    p14_score_bcd_if bus1();

    assign bus0.v_sync = v_sync;
    assign bus0.score  = score;
    assign bus1.v_sync = v_sync;
    assign bus1.score  = score;

    p14_score_bcd #(.SYNC_ACTIVE_LOW(1'b1), .SKIP_UNCHANGED(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
    );
    p14_score_bcd #(.SYNC_ACTIVE_LOW(1'b1), .SKIP_UNCHANGED(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
    );

    logic [3:0] a_h[2], a_t[2], a_o[2];
    logic [7:0] a_best[2];
    logic       a_v[2], a_r[2], a_b[2];

    assign a_h[0] = bus0.bcd_hundreds;  assign a_h[1] = bus1.bcd_hundreds;
    assign a_t[0] = bus0.bcd_tens;      assign a_t[1] = bus1.bcd_tens;
    assign a_o[0] = bus0.bcd_ones;      assign a_o[1] = bus1.bcd_ones;
    assign a_best[0] = bus0.best_score; assign a_best[1] = bus1.best_score;
    assign a_v[0] = bus0.bcd_valid;     assign a_v[1] = bus1.bcd_valid;
    assign a_r[0] = bus0.bcd_ready;     assign a_r[1] = bus1.bcd_ready;
    assign a_b[0] = bus0.busy;          assign a_b[1] = bus1.busy;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int inst, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[dut%0d] @%0t: got %0d expected %0d", name, inst, $time, act, exp);
        end
    endtask

    // Timeline model: a conversion accepted at edge n occupies edges n..n+8 and publishes at edge n+9.
    int m_rem[2], m_pend[2], m_last[2], m_best[2];
    int m_h[2], m_t[2], m_o[2];
    bit m_valid[2], m_ready[2];
    bit m_prev;

    task automatic model_reset();
        m_prev = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_rem[i] = 0; m_pend[i] = 0; m_last[i] = 0; m_best[i] = 0;
            m_h[i] = 0; m_t[i] = 0; m_o[i] = 0;
            m_valid[i] = 1'b0; m_ready[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit act, trig, was_busy, skip;
        act    = (v_sync == 1'b0);
        trig   = act && !m_prev;
        m_prev = act;
        for (int i = 0; i < 2; i++) begin
            was_busy   = (m_rem[i] > 0);
            m_valid[i] = 1'b0;
            if (was_busy) begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_h[i] = m_pend[i] / 100;
                    m_t[i] = (m_pend[i] / 10) % 10;
                    m_o[i] = m_pend[i] % 10;
                    m_valid[i] = 1'b1;
                    m_ready[i] = 1'b1;
                end
            end
            skip = (i == 1) && m_ready[i] && (int'(score) == m_last[i]);
            if (!was_busy && trig && !skip) begin
                m_rem[i]  = 9;
                m_pend[i] = score;
                m_last[i] = score;
                if (int'(score) > m_best[i]) m_best[i] = score;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    int vcnt[2] = '{0, 0};
    bit prev_v[2] = '{1'b0, 1'b0};

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("hundreds",   i, a_h[i],    m_h[i]);
                chk("tens",       i, a_t[i],    m_t[i]);
                chk("ones",       i, a_o[i],    m_o[i]);
                chk("best_score", i, a_best[i], m_best[i]);
                chk("bcd_valid",  i, a_v[i],    m_valid[i]);
                chk("bcd_ready",  i, a_r[i],    m_ready[i]);
                chk("busy",       i, a_b[i],    (m_rem[i] > 0) ? 1 : 0);
                chk("valid_back_to_back", i, (a_v[i] && prev_v[i]) ? 1 : 0, 0);
                chk("hundreds_range", i, (a_h[i] > 4'd2) ? 1 : 0, 0);
                prev_v[i] = a_v[i];
                if (a_v[i]) vcnt[i]++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int s, input int gap);
        @(negedge clk);
        score  = 8'(s);
        v_sync = 1'b0;
        cyc(2);
        v_sync = 1'b1;
        cyc(gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #5 rst_n = 1'b0;
        @(negedge clk);
        #5 rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic digits(input string name, input int h, input int t, input int o);
        chk({name, "_h"}, 0, a_h[0], h);
        chk({name, "_t"}, 0, a_t[0], t);
        chk({name, "_o"}, 0, a_o[0], o);
    endtask

    int v0, v1;

    initial begin
        v_sync = 1'b1;
        score  = 8'd0;
        rst_n  = 1'b0;
        #1;
        chk("reset_busy",  0, a_b[0], 0);
        chk("reset_ready", 0, a_r[0], 0);
        cyc(3);
        #5 rst_n = 1'b1;
        cyc(2);

        // 255: full-scale digits and best score
        v0 = vcnt[0]; v1 = vcnt[1];
        frame(255, 12);
        digits("s255", 2, 5, 5);
        chk("s255_best",   0, a_best[0], 255);
        chk("s255_pulses", 0, vcnt[0] - v0, 1);
        chk("s255_pulses", 1, vcnt[1] - v1, 1);

        // 0, 99, 100 sequence from reset
        do_reset();
        frame(0, 12);
        digits("s0", 0, 0, 0);
        chk("s0_ready", 0, a_r[0], 1);
        frame(99, 12);
        digits("s99", 0, 9, 9);
        frame(100, 12);
        digits("s100", 1, 0, 0);
        chk("s100_best", 0, a_best[0], 100);

        // lower score does not replace best
        do_reset();
        frame(37, 12);
        frame(12, 12);
        digits("s12", 0, 1, 2);
        chk("s12_best", 0, a_best[0], 37);

        // second edge three cycles into a conversion is dropped
        do_reset();
        v0 = vcnt[0];
        @(negedge clk);
        score  = 8'd42;
        v_sync = 1'b0;
        cyc(1);
        v_sync = 1'b1;
        cyc(2);
        score  = 8'd77;
        v_sync = 1'b0;
        cyc(1);
        v_sync = 1'b1;
        cyc(14);
        digits("s42", 0, 4, 2);
        chk("s42_best",   0, a_best[0], 42);
        chk("s42_pulses", 0, vcnt[0] - v0, 1);

        // unchanged score: skipped only on the SKIP_UNCHANGED instance
        do_reset();
        v0 = vcnt[0]; v1 = vcnt[1];
        frame(50, 12);
        frame(50, 12);
        chk("skip_pulses", 0, vcnt[0] - v0, 2);
        chk("skip_pulses", 1, vcnt[1] - v1, 1);

        // reset at edge 4 of a conversion of 200
        do_reset();
        v0 = vcnt[0];
        @(negedge clk);
        score  = 8'd200;
        v_sync = 1'b0;
        @(posedge clk);
        @(negedge clk);
        v_sync = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("abort_busy",  i, a_b[i], 0);
            chk("abort_ready", i, a_r[i], 0);
            chk("abort_best",  i, a_best[i], 0);
            chk("abort_digits", i, {a_h[i], a_t[i], a_o[i]}, 0);
        end
        cyc(2);
        #5 rst_n = 1'b1;
        cyc(15);
        chk("abort_no_pulse", 0, vcnt[0] - v0, 0);
        chk("abort_ready_after", 0, a_r[0], 0);

        // exhaustive sweep
        for (int v = 0; v < 256; v++) begin
            frame(v, 10);
            chk("sweep_h", 0, a_h[0], v / 100);
            chk("sweep_t", 0, a_t[0], (v / 10) % 10);
            chk("sweep_o", 0, a_o[0], v % 10);
        end

        // random phase: free-running v_sync, score churn, occasional resets
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) v_sync = ~v_sync;
            if ($urandom_range(0, 9) == 0)
                score = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #5 rst_n = 1'b0;
                @(negedge clk);
                #5 rst_n = 1'b1;
            end
        end
        cyc(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/p14_score_bcd.md
P14_SCORE_BCD -- requirements
Module: p14_score_bcd

Interface
REQ-001 The block SHALL have parameter SYNC_ACTIVE_LOW, default 1, meaning v_sync is active-low (0 selects active-high).
REQ-002 The block SHALL have parameter SKIP_UNCHANGED, default 0, meaning when 1 a trigger is ignored if score equals the last converted value and bcd_ready=1.
REQ-003 clk  input  1  system clock (25 MHz pixel clock).
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 v_sync  input  1  vertical sync from the VGA timing stage; frame trigger source.
REQ-006 score  input  8  binary game score from game control.
REQ-007 bcd_hundreds  output  4  BCD hundreds digit of the last converted score (0-2).
REQ-008 bcd_tens  output  4  BCD tens digit.
REQ-009 bcd_ones  output  4  BCD ones digit.
REQ-010 best_score  output  8  highest score sampled since reset, binary.
REQ-011 bcd_valid  output  1  one-cycle pulse when digit outputs update.
REQ-012 bcd_ready  output  1  level; high once at least one conversion has completed since reset.
REQ-013 busy  output  1  high while a conversion is in progress.

Function
REQ-014 v_sync SHALL be registered once into v_sync_d; trigger = v_sync sampled active while v_sync_d inactive (polarity per SYNC_ACTIVE_LOW).
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE; reset state IDLE.
REQ-016 IDLE on trigger edge (edge 0): load 20-bit shift register {12'b0, score}, capture score into last_score, clear 3-bit shift count, go to SHIFT, set busy=1.
REQ-017 On the same edge 0, best_score SHALL be loaded with score if score > best_score (unsigned), else held.
REQ-018 SHIFT, each of edges 1-8: for each BCD nibble of the shift register ([11:8], [15:12], [19:16]) add 3 if nibble >= 5, then shift the whole register left 1; after edge 8 go to DONE.
REQ-019 DONE (edge 9): bcd_hundreds/tens/ones <= register [19:16]/[15:12]/[11:8]; bcd_valid=1 for exactly this one cycle; bcd_ready=1; busy=0; go to IDLE.
REQ-020 Total latency SHALL be 9 clock edges from trigger to digit update; digit outputs SHALL hold stable between updates.
REQ-021 Triggers arriving while busy=1 SHALL be ignored (no queueing); best_score is also not updated for them.
REQ-022 score changes after edge 0 SHALL NOT affect the conversion in progress.
REQ-023 With SKIP_UNCHANGED=1, bcd_ready=1, and score==last_score at a trigger, the FSM SHALL stay IDLE, no bcd_valid pulse, best_score unchanged.
REQ-024 Conversion SHALL be exact for all 256 inputs; hundreds nibble SHALL never exceed 2.
REQ-025 bcd_valid SHALL never be high in two consecutive cycles.
REQ-026 If v_sync is active at reset release, the first sampling edge SHALL count as a trigger (v_sync_d resets to inactive).

Reset
REQ-027 On rst_n low, immediately and regardless of clk: state IDLE; digits 0; best_score 0; bcd_valid 0; bcd_ready 0; busy 0; shift register, count, last_score 0; v_sync_d inactive.
REQ-028 Reset mid-conversion SHALL abort it; no bcd_valid pulse SHALL follow reset release without a new trigger.

Verification
REQ-029 score=255, one v_sync falling edge -> 9 edges later digits 2/5/5, bcd_valid one cycle, best_score=255, busy high edges 0-8.
REQ-030 Frame sequence score=0,99,100 -> digits 0/0/0, 0/9/9, 1/0/0; bcd_ready high after first; best_score 100.
REQ-031 score=37 frame, then 12 frame -> digits 1/2 after second, best_score stays 37.
REQ-032 Second v_sync edge 3 cycles after first (score changed 42->77) -> ignored, digits 0/4/2, single bcd_valid.
REQ-033 SKIP_UNCHANGED=1, score=50 two frames -> one bcd_valid only; SKIP_UNCHANGED=0 -> two pulses.
REQ-034 rst_n asserted at edge 4 of a conversion of 200 -> all outputs 0 asynchronously; no pulse after release until next trigger; exhaustive sweep 0-255 matches reference digits.
